// File: rtl/enc_pkg.sv
// enc_pkg: shared types, defaults and helpers for the registered priority encoders
package enc_pkg;
  typedef enum logic {EMPTY, FULL} state_t;
  localparam int N_DEF = 8;
  localparam int CW_DEF = 8;
  function automatic longint unsigned sat_max(input int cw);
    return (64'd1 << cw) - 64'd1;
  endfunction
endpackage

// File: rtl/prio_enc_core.sv
// prio_enc_core: combinational priority encoder, highest set index wins, gated by enable
module prio_enc_core #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         i_e,
  input  logic [N-1:0] i_d,
  output logic [W-1:0] o_y,
  output logic         o_v,
  output logic         o_m
);
  // scan upward so later (higher) set bits overwrite the index; a set bit seen after another marks multi-hot
  always_comb begin
    o_y = '0;
    o_v = 1'b0;
    o_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_e && i_d[i]) begin
        o_m = o_m | o_v;
        o_v = 1'b1;
        o_y = W'(i);
      end
    end
  end
endmodule

// File: rtl/prio_enc_8to3_reg.sv
// prio_enc_8to3_reg: priority encoder with single-entry output buffer and multi-hot counter
module prio_enc_8to3_reg
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int CW = CW_DEF,
  localparam int W = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          E,
  input  logic [N-1:0]  D,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  Y,
  output logic          V,
  output logic          M,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          cnt_clr,
  output logic [CW-1:0] err_cnt
);
  localparam logic [CW-1:0] CNT_MAX = CW'(sat_max(CW));
  state_t r_state, w_next;
  logic [W-1:0] w_y;
  logic w_v, w_m, w_acc;
  assign w_acc = in_valid & in_ready;
  prio_enc_core #(.N(N)) u_core (
    .i_e(E),
    .i_d(D),
    .o_y(w_y),
    .o_v(w_v),
    .o_m(w_m)
  );
  // state register: empty after reset, any held result is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end
  // next state: an accept always leaves a result; a drained result with nothing new empties the buffer
  always_comb begin
    w_next = w_acc ? FULL : ((r_state == FULL) && out_ready) ? EMPTY : r_state;
  end
  // outputs: a slot is free when empty or when the held result is being taken this cycle
  always_comb begin
    out_valid = (r_state == FULL);
    in_ready  = (r_state == EMPTY) | out_ready;
  end
  // result registers load only on accept and otherwise keep (possibly stale) contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y <= '0;
      V <= 1'b0;
      M <= 1'b0;
    end else if (w_acc) begin
      Y <= w_y;
      V <= w_v;
      M <= w_m;
    end
  end
  // multi-hot counter saturates, and a clear overrides a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_cnt <= '0;
    else if (cnt_clr)                               err_cnt <= '0;
    else if (w_acc && w_m && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CW'(1);
  end
endmodule

// File: tb/tb_prio_enc_8to3_reg.sv
// tb_prio_enc_8to3_reg: randomized and directed checks against a behavioural model
module tb_prio_enc_8to3_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic E = 1'b0;
  logic [7:0] D = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] Y;
  logic V, M, out_valid;
  logic out_ready = 1'b0;
  logic cnt_clr = 1'b0;
  logic [7:0] err_cnt;
  int errors = 0;
  int checks = 0;
  logic m_full = 1'b0;
  logic [2:0] m_y = '0;
  logic m_v = 1'b0, m_m = 1'b0;
  int m_cnt = 0;
  logic m_rdy;
  logic [13:0] got, exp;

  prio_enc_8to3_reg dut (
    .clk(clk), .rst_n(rst_n), .E(E), .D(D), .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .V(V), .M(M), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic void enc(input logic e, input logic [7:0] d,
                              output logic [2:0] y, output logic v, output logic m);
    logic found;
    found = 1'b0;
    y = 3'd0;
    v = e && (d != 8'd0);
    m = e && ($countones(d) > 1);
    if (v)
      for (int i = 7; i >= 0; i--)
        if (d[i] && !found) begin
          y = 3'(i);
          found = 1'b1;
        end
  endfunction

  function automatic void model_reset();
    m_full = 1'b0; m_y = '0; m_v = 1'b0; m_m = 1'b0; m_cnt = 0;
  endfunction

  task automatic drive(input logic e, input logic [7:0] d, input logic iv,
                       input logic ordy, input logic clr);
    E = e; D = d; in_valid = iv; out_ready = ordy; cnt_clr = clr;
    m_rdy = !m_full || ordy;
    #1;
  endtask

  task automatic tick();
    logic acc, y_n, v_n;
    logic [2:0] yy;
    logic vv, mm;
    acc = in_valid && (!m_full || out_ready);
    enc(E, D, yy, vv, mm);
    @(posedge clk);
    if (cnt_clr) m_cnt = 0;
    else if (acc && mm && m_cnt < 255) m_cnt++;
    if (acc) begin m_y = yy; m_v = vv; m_m = mm; end
    m_full = acc ? 1'b1 : (out_ready ? 1'b0 : m_full);
    #1;
    got = {out_valid, Y, V, M, err_cnt};
    exp = {m_full, m_y, m_v, m_m, 8'(m_cnt)};
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, Y, V, M, err_cnt} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, Y, V, M, err_cnt});
    end
    #10 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_encode();
    drive(1, 8'b0010_0100, 1, 1, 0); tick();
    checks++;
    if ({out_valid, Y, V, M, err_cnt} !== {1'b1, 3'd5, 1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL enc_24 got=%h exp=%h", got, {1'b1, 3'd5, 1'b1, 1'b1, 8'd1});
    end
    drive(0, 8'hFF, 1, 1, 0); tick();
    checks++;
    if ({out_valid, Y, V, M, err_cnt} !== {1'b1, 3'd0, 1'b0, 1'b0, 8'd1}) begin
      errors++; $display("FAIL enc_disabled got=%h exp=%h", got, {1'b1, 3'd0, 1'b0, 1'b0, 8'd1});
    end
    drive(1, 8'h00, 1, 1, 0); tick();
    checks++;
    if ({out_valid, Y, V, M} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL enc_zero got=%h exp=%h", got[13:8], {1'b1, 3'd0, 1'b0, 1'b0});
    end
    drive(1, 8'h80, 1, 1, 0); tick();
    checks++;
    if ({out_valid, Y, V, M} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL enc_80 got=%h exp=%h", got[13:8], {1'b1, 3'd7, 1'b1, 1'b0});
    end
    drive(0, 8'h00, 0, 1, 0); tick();
    checks++;
    if (out_valid !== 1'b0 || Y !== 3'd7) begin
      errors++; $display("FAIL drain out_valid=%b Y=%0d exp 0/7", out_valid, Y);
    end
  endtask

  task automatic test_stall();
    drive(1, 8'h08, 1, 1, 0); tick();
    checks++;
    if (got !== exp || Y !== 3'd3) begin
      errors++; $display("FAIL stall_load got=%h exp=%h", got, exp);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'h40, 1, 0, 0);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready cyc=%0d in_ready=%b exp 0", k, in_ready);
      end
      tick();
      checks++;
      if (Y !== 3'd3 || out_valid !== 1'b1 || got !== exp) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
    drive(1, 8'h40, 1, 1, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release in_ready=%b exp 1", in_ready);
    end
    tick();
    checks++;
    if (Y !== 3'd6 || out_valid !== 1'b1 || got !== exp) begin
      errors++; $display("FAIL stall_take got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      checks++;
      if (in_ready !== m_rdy) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", k, in_ready, m_rdy);
      end
      tick();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_saturate();
    drive(0, 8'h00, 0, 1, 1); tick();
    for (int k = 0; k < 260; k++) begin
      drive(1, 8'hC3, 1, 1, 0); tick();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL sat_step cyc=%0d got=%h exp=%h", k, got, exp);
      end
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_max err_cnt=%0d exp 255", err_cnt);
    end
    drive(1, 8'h11, 1, 1, 1); tick();
    checks++;
    if (err_cnt !== 8'd0 || got !== exp) begin
      errors++; $display("FAIL clr_wins err_cnt=%0d exp 0", err_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 8'h24, 1, 1, 0); tick();
    drive(1, 8'h30, 1, 0, 0); tick();
    checks++;
    if (out_valid !== 1'b1 || err_cnt === 8'd0 || got !== exp) begin
      errors++; $display("FAIL areset_setup got=%h exp=%h", got, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, Y, V, M, err_cnt} !== 14'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_async got=%h in_ready=%b exp 0/1", {out_valid, Y, V, M, err_cnt}, in_ready);
    end
    model_reset();
    drive(0, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL areset_after got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_stall();
    test_random();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prio_enc_8to3_reg.md
# prio_enc_8to3_reg

Registered priority encoder with enable and a valid/ready handshake, the inverse of the team's enabled one-hot decoders. It accepts an N-bit request vector, encodes the highest-index asserted bit into a binary address with an "any active" flag and a multi-hot flag, and holds the result in a single-entry output buffer until the consumer takes it. A saturating counter records multi-hot samples for debug. It sits between request sources (buttons, interrupt lines, decoder outputs under test) and any consumer that needs a compact binary index.

## Interface
Parameters:
- N, 8, request vector width; legal values 2..16
- W, $clog2(N), address width; derived, not overridden
- CW, 8, error counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- E  input  1  encode enable, sampled with the request
- D  input  N  request vector, bit N-1 has highest priority
- in_valid  input  1  D/E valid this cycle
- in_ready  output  1  block can accept a sample this cycle
- Y  output  W  encoded address of highest set bit
- V  output  1  at least one bit of D was set, with E=1
- M  output  1  more than one bit of D was set, with E=1
- out_valid  output  1  Y/V/M hold a result
- out_ready  input  1  consumer takes the result this cycle
- cnt_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  CW  saturating count of accepted multi-hot samples

## Operation
- Accept: in_valid & in_ready in the same cycle.
- Encode (on accept): E=0 → Y=0, V=0, M=0 regardless of D. E=1 → Y = index of highest set bit of D (0 if D=0), V = |D, M = popcount(D) > 1.
- FSM, two states:
  - EMPTY: out_valid=0, in_ready=1. Accept → FULL, load Y/V/M.
  - FULL: out_valid=1, in_ready=out_ready. out_ready & accept → stay FULL, load new result. out_ready & no accept → EMPTY. out_ready=0 → hold Y/V/M unchanged, no accept.
- Y/V/M change only on accept; they are not cleared when leaving FULL (stale but gated by out_valid).
- err_cnt: +1 on an accept with E=1 and M computed as 1; saturates at 2^CW-1, never wraps. cnt_clr=1 → 0 next edge; clr and increment in the same cycle → 0 (clear wins).
- in_valid with in_ready=0: sample ignored, no counter effect; source must hold it.

## Timing
- Reset (rst_n=0, any time, asynchronous): state=EMPTY, out_valid=0, Y=0, V=0, M=0, err_cnt=0; in_ready=1 on the first cycle after release. A held result is discarded.
- Latency: accept at edge k → out_valid=1 and result visible after edge k, i.e. 1 cycle.
- Throughput: one result per cycle when out_ready is held high.
- in_ready is combinational from out_ready and state only (no path from in_valid); all other outputs are registered.
- err_cnt updates on the same edge as the accepting transfer.

## Structure
- Shared package enc_pkg: state enum {EMPTY, FULL}, default N/CW constants, saturation max as a function of CW.
- One sub-module: prio_enc_core, purely combinational (D, E → Y, V, M) using a loop from bit 0 upward so the highest index wins; reusable by other encoders.
- Top holds the FSM, output registers and err_cnt.

## Test plan
- Reset then E=1, D=8'b0010_0100, in_valid=1, out_ready=1 → next cycle out_valid=1, Y=5, V=1, M=1, err_cnt=1.
- E=0, D=8'hFF accepted → Y=0, V=0, M=0, err_cnt unchanged.
- E=1, D=8'h00 → Y=0, V=0, M=0; D=8'h80 → Y=7, V=1, M=0.
- out_ready=0 while FULL with Y=3, new in_valid with D=8'h40 → in_ready=0, Y stays 3 for all stall cycles; out_ready=1 → D=8'h40 accepted same cycle, Y=6 next.
- 260 consecutive multi-hot accepts (CW=8) → err_cnt stops at 255; cnt_clr=1 concurrent with a multi-hot accept → err_cnt=0.
- rst_n pulled low mid-cycle while FULL → out_valid, Y, err_cnt go 0 immediately without a clock edge.
